// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle MIPS control unit and its datapath:
// instruction fields, FSM states, mux-select encodings and the control word.
package cpu_pkg;

    localparam int unsigned SP_INIT = 227;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OpR    = 6'h00;
    localparam logic [5:0] OpJ    = 6'h02;
    localparam logic [5:0] OpJal  = 6'h03;
    localparam logic [5:0] OpBeq  = 6'h04;
    localparam logic [5:0] OpBne  = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08;
    localparam logic [5:0] OpLui  = 6'h0F;
    localparam logic [5:0] OpLw   = 6'h23;
    localparam logic [5:0] OpSw   = 6'h2B;

    // R-type functs (IR[5:0])
    localparam logic [5:0] FnSll   = 6'h00;
    localparam logic [5:0] FnSrl   = 6'h02;
    localparam logic [5:0] FnJr    = 6'h08;
    localparam logic [5:0] FnBreak = 6'h0D;
    localparam logic [5:0] FnMfhi  = 6'h10;
    localparam logic [5:0] FnMflo  = 6'h12;
    localparam logic [5:0] FnRte   = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnDiv   = 6'h1A;
    localparam logic [5:0] FnAdd   = 6'h20;
    localparam logic [5:0] FnSub   = 6'h22;
    localparam logic [5:0] FnAnd   = 6'h24;

    localparam logic [1:0] IordPc     = 2'd0;
    localparam logic [1:0] IordAluOut = 2'd1;
    localparam logic [1:0] IordExcp   = 2'd2;
    localparam logic [1:0] IordAluRes = 2'd3;

    localparam logic [1:0] ExcpOp   = 2'd0;
    localparam logic [1:0] ExcpOvf  = 2'd1;
    localparam logic [1:0] ExcpDiv0 = 2'd2;

    localparam logic [1:0] SrcAPc  = 2'd0;
    localparam logic [1:0] SrcAA   = 2'd1;
    localparam logic [1:0] SrcAMdr = 2'd2;

    localparam logic [1:0] SrcBB     = 2'd0;
    localparam logic [1:0] SrcB4     = 2'd1;
    localparam logic [1:0] SrcBImm   = 2'd2;
    localparam logic [1:0] SrcBImmSh = 2'd3;

    localparam logic [2:0] AluPassA = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b001;
    localparam logic [2:0] AluSub   = 3'b010;
    localparam logic [2:0] AluAnd   = 3'b011;
    localparam logic [2:0] AluCmp   = 3'b111;

    localparam logic [2:0] WrRt = 3'd0;
    localparam logic [2:0] WrRd = 3'd1;
    localparam logic [2:0] WrSp = 3'd2;
    localparam logic [2:0] WrK1 = 3'd3;
    localparam logic [2:0] WrRa = 3'd4;

    // DataPc (4) carries the already-incremented PC into $31 for jal.
    localparam logic [3:0] DataAluOut = 4'd0;
    localparam logic [3:0] DataLs     = 4'd1;
    localparam logic [3:0] DataHi     = 4'd2;
    localparam logic [3:0] DataLo     = 4'd3;
    localparam logic [3:0] DataPc     = 4'd4;
    localparam logic [3:0] DataLui    = 4'd5;
    localparam logic [3:0] DataShift  = 4'd7;
    localparam logic [3:0] DataSpInit = 4'd8;

    localparam logic [2:0] PcAluRes = 3'd0;
    localparam logic [2:0] PcAluOut = 3'd1;
    localparam logic [2:0] PcJump   = 3'd2;
    localparam logic [2:0] PcEpc    = 3'd4;
    localparam logic [2:0] PcLs     = 3'd5;

    localparam logic [1:0] LsWord = 2'd0;
    localparam logic [1:0] LsByte = 2'd2;

    localparam logic [2:0] ShNop  = 3'd0;
    localparam logic [2:0] ShLoad = 3'd1;
    localparam logic [2:0] ShSll  = 3'd2;
    localparam logic [2:0] ShSrl  = 3'd3;

    typedef enum logic [5:0] {
        StReset, StFetch, StFetchLd, StDecode,
        StExecAdd, StExecSub, StExecAnd, StExecAddi, StWbRd, StWbRt, StLui,
        StMemAddr, StMemRead, StMemLd, StMemWb, StMemWrite,
        StBeq, StBne, StBranchTake, StJump, StJal, StJr,
        StShLoad, StSll, StSrl, StShWb, StMfhi, StMflo, StRte, StBreak,
        StMultStart, StMultWait, StMultDone, StDivStart, StDivWait, StDivDone,
        StExcpEpc, StExcpRead, StExcpPc
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       ab_write;
        logic       mdr_write;
        logic       alu_out_write;
        logic       epc_write;
        logic       mult_start;
        logic       div_start;
        logic       hilo_write;
        logic [1:0] iord;
        logic [1:0] excp_control;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] src_write;
        logic [3:0] src_data;
        logic [2:0] pc_source;
        logic [1:0] ls_control;
        logic [2:0] shift_control;
    } ctrl_t;

    // First execute state for a decoded instruction; StExcpEpc flags an illegal encoding.
    function automatic state_e decode_state(logic [5:0] op, logic [5:0] fn);
        state_e st;
        st = StExcpEpc;
        if (op == OpR) begin
            case (fn)
                FnAdd:        st = StExecAdd;
                FnSub:        st = StExecSub;
                FnAnd:        st = StExecAnd;
                FnSll, FnSrl: st = StShLoad;
                FnJr:         st = StJr;
                FnMfhi:       st = StMfhi;
                FnMflo:       st = StMflo;
                FnMult:       st = StMultStart;
                FnDiv:        st = StDivStart;
                FnRte:        st = StRte;
                FnBreak:      st = StBreak;
                default:      st = StExcpEpc;
            endcase
        end else begin
            case (op)
                OpAddi:     st = StExecAddi;
                OpLui:      st = StLui;
                OpLw, OpSw: st = StMemAddr;
                OpBeq:      st = StBeq;
                OpBne:      st = StBne;
                OpJ:        st = StJump;
                OpJal:      st = StJal;
                default:    st = StExcpEpc;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the MIPS datapath: one instruction at a time,
// with opcode, overflow and divide-by-zero exceptions routed through EPC.
module control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MemWait = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       overflow_i,
    input  logic       zero_i,
    input  logic       div_zero_i,
    input  logic       mult_done_i,
    input  logic       div_done_i,
    output logic       pc_write_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       ab_write_o,
    output logic       mdr_write_o,
    output logic       alu_out_write_o,
    output logic       epc_write_o,
    output logic       mult_start_o,
    output logic       div_start_o,
    output logic       hilo_write_o,
    output logic [1:0] iord_o,
    output logic [1:0] excp_control_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_control_o,
    output logic [2:0] src_write_o,
    output logic [3:0] src_data_o,
    output logic [2:0] pc_source_o,
    output logic [1:0] ls_control_o,
    output logic [2:0] shift_control_o
);

    localparam int unsigned CntW = (MemWait > 1) ? $clog2(MemWait) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MemWait - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      excp_q, excp_d;
    ctrl_t           ctrl, ctrl_out;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StReset;
            cnt_q   <= '0;
            excp_q  <= ExcpOp;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            excp_q  <= excp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        excp_d  = excp_q;
        unique case (state_q)
            StReset:   state_d = StFetch;
            StFetch: begin
                if (cnt_q == CntLast) state_d = StFetchLd;
                else cnt_d = cnt_q + 1'b1;
            end
            StFetchLd: state_d = StDecode;
            StDecode: begin
                state_d = decode_state(opcode_i, funct_i);
                if (state_d == StExcpEpc) excp_d = ExcpOp;
            end
            StExecAdd, StExecSub: begin
                if (overflow_i) begin
                    state_d = StExcpEpc;
                    excp_d  = ExcpOvf;
                end else begin
                    state_d = StWbRd;
                end
            end
            StExecAnd: state_d = StWbRd;
            StExecAddi: begin
                if (overflow_i) begin
                    state_d = StExcpEpc;
                    excp_d  = ExcpOvf;
                end else begin
                    state_d = StWbRt;
                end
            end
            StMemAddr: state_d = (opcode_i == OpLw) ? StMemRead : StMemWrite;
            StMemRead: begin
                if (cnt_q == CntLast) state_d = StMemLd;
                else cnt_d = cnt_q + 1'b1;
            end
            StMemLd:   state_d = StMemWb;
            StBeq:     state_d = zero_i ? StBranchTake : StFetch;
            StBne:     state_d = zero_i ? StFetch : StBranchTake;
            StShLoad:  state_d = (funct_i == FnSll) ? StSll : StSrl;
            StSll, StSrl: state_d = StShWb;
            StMultStart: state_d = StMultWait;
            StMultWait:  if (mult_done_i) state_d = StMultDone;
            StDivStart: begin
                if (div_zero_i) begin
                    state_d = StExcpEpc;
                    excp_d  = ExcpDiv0;
                end else begin
                    state_d = StDivWait;
                end
            end
            StDivWait:   if (div_done_i) state_d = StDivDone;
            StExcpEpc:   state_d = StExcpRead;
            StExcpRead: begin
                if (cnt_q == CntLast) state_d = StExcpPc;
                else cnt_d = cnt_q + 1'b1;
            end
            StWbRd, StWbRt, StLui, StMemWb, StMemWrite, StBranchTake, StJump, StJal, StJr,
            StShWb, StMfhi, StMflo, StRte, StBreak, StMultDone, StDivDone, StExcpPc:
                state_d = StFetch;
            default:     state_d = StReset;
        endcase
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            StReset: begin
                ctrl.reg_write = 1'b1;
                ctrl.src_write = WrSp;
                ctrl.src_data  = DataSpInit;
            end
            StFetch, StFetchLd: begin
                ctrl.iord        = IordPc;
                ctrl.alu_src_a   = SrcAPc;
                ctrl.alu_src_b   = SrcB4;
                ctrl.alu_control = AluAdd;
                ctrl.pc_source   = PcAluRes;
                ctrl.ir_write    = (state_q == StFetchLd);
                ctrl.pc_write    = (state_q == StFetchLd);
            end
            StDecode: begin
                ctrl.ab_write      = 1'b1;
                ctrl.alu_src_a     = SrcAPc;
                ctrl.alu_src_b     = SrcBImmSh;
                ctrl.alu_control   = AluAdd;
                ctrl.alu_out_write = 1'b1;
            end
            StExecAdd, StExecSub, StExecAnd: begin
                ctrl.alu_src_a     = SrcAA;
                ctrl.alu_src_b     = SrcBB;
                ctrl.alu_out_write = 1'b1;
                ctrl.alu_control   = (state_q == StExecAdd) ? AluAdd :
                                     (state_q == StExecSub) ? AluSub : AluAnd;
            end
            StExecAddi, StMemAddr: begin
                ctrl.alu_src_a     = SrcAA;
                ctrl.alu_src_b     = SrcBImm;
                ctrl.alu_control   = AluAdd;
                ctrl.alu_out_write = 1'b1;
            end
            StWbRd, StWbRt: begin
                ctrl.reg_write = 1'b1;
                ctrl.src_write = (state_q == StWbRd) ? WrRd : WrRt;
                ctrl.src_data  = DataAluOut;
            end
            StLui: begin
                ctrl.reg_write = 1'b1;
                ctrl.src_write = WrRt;
                ctrl.src_data  = DataLui;
            end
            StMemRead:  ctrl.iord = IordAluOut;
            StMemLd: begin
                ctrl.iord      = IordAluOut;
                ctrl.mdr_write = 1'b1;
            end
            StMemWb: begin
                ctrl.reg_write  = 1'b1;
                ctrl.src_write  = WrRt;
                ctrl.src_data   = DataLs;
                ctrl.ls_control = LsWord;
            end
            StMemWrite: begin
                ctrl.iord      = IordAluOut;
                ctrl.mem_write = 1'b1;
            end
            StBeq, StBne: begin
                ctrl.alu_src_a   = SrcAA;
                ctrl.alu_src_b   = SrcBB;
                ctrl.alu_control = AluCmp;
            end
            StBranchTake: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcAluOut;
            end
            StJump, StJal: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcJump;
                ctrl.reg_write = (state_q == StJal);
                ctrl.src_write = (state_q == StJal) ? WrRa : WrRt;
                ctrl.src_data  = (state_q == StJal) ? DataPc : DataAluOut;
            end
            StJr: begin
                ctrl.alu_src_a   = SrcAA;
                ctrl.alu_control = AluPassA;
                ctrl.pc_source   = PcAluRes;
                ctrl.pc_write    = 1'b1;
            end
            StShLoad:   ctrl.shift_control = ShLoad;
            StSll:      ctrl.shift_control = ShSll;
            StSrl:      ctrl.shift_control = ShSrl;
            StShWb, StMfhi, StMflo: begin
                ctrl.reg_write = 1'b1;
                ctrl.src_write = WrRd;
                ctrl.src_data  = (state_q == StShWb) ? DataShift :
                                 (state_q == StMfhi) ? DataHi : DataLo;
            end
            StRte: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PcEpc;
            end
            // PC already points past break; stepping back re-fetches it forever.
            StBreak: begin
                ctrl.alu_src_a   = SrcAPc;
                ctrl.alu_src_b   = SrcB4;
                ctrl.alu_control = AluSub;
                ctrl.pc_source   = PcAluRes;
                ctrl.pc_write    = 1'b1;
            end
            StMultStart: ctrl.mult_start = 1'b1;
            StDivStart:  ctrl.div_start = 1'b1;
            StMultDone, StDivDone: ctrl.hilo_write = 1'b1;
            StExcpEpc: begin
                ctrl.alu_src_a    = SrcAPc;
                ctrl.alu_src_b    = SrcB4;
                ctrl.alu_control  = AluSub;
                ctrl.epc_write    = 1'b1;
                ctrl.excp_control = excp_q;
            end
            StExcpRead: begin
                ctrl.iord         = IordExcp;
                ctrl.excp_control = excp_q;
            end
            StExcpPc: begin
                ctrl.iord         = IordExcp;
                ctrl.excp_control = excp_q;
                ctrl.pc_source    = PcLs;
                ctrl.ls_control   = LsByte;
                ctrl.pc_write     = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // Outputs stay low for as long as reset is held, even mid-instruction.
    assign ctrl_out = rst_i ? '0 : ctrl;

    assign pc_write_o      = ctrl_out.pc_write;
    assign mem_write_o     = ctrl_out.mem_write;
    assign ir_write_o      = ctrl_out.ir_write;
    assign reg_write_o     = ctrl_out.reg_write;
    assign ab_write_o      = ctrl_out.ab_write;
    assign mdr_write_o     = ctrl_out.mdr_write;
    assign alu_out_write_o = ctrl_out.alu_out_write;
    assign epc_write_o     = ctrl_out.epc_write;
    assign mult_start_o    = ctrl_out.mult_start;
    assign div_start_o     = ctrl_out.div_start;
    assign hilo_write_o    = ctrl_out.hilo_write;
    assign iord_o          = ctrl_out.iord;
    assign excp_control_o  = ctrl_out.excp_control;
    assign alu_src_a_o     = ctrl_out.alu_src_a;
    assign alu_src_b_o     = ctrl_out.alu_src_b;
    assign alu_control_o   = ctrl_out.alu_control;
    assign src_write_o     = ctrl_out.src_write;
    assign src_data_o      = ctrl_out.src_data;
    assign pc_source_o     = ctrl_out.pc_source;
    assign ls_control_o    = ctrl_out.ls_control;
    assign shift_control_o = ctrl_out.shift_control;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected control-word sequences, compared every cycle.
module tb_control_unit;
    import cpu_pkg::*;

    localparam int unsigned MemWait = 2;

    typedef enum int {
        KAdd, KSub, KAnd, KAddi, KLui, KLw, KSw, KBeq, KBne, KJ, KJal, KJr,
        KSll, KSrl, KMfhi, KMflo, KRte, KBreak, KMult, KDiv, KBadOp, KBadFn
    } kind_e;

    typedef struct {
        ctrl_t c;
        logic  md;
        logic  dd;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       overflow = 1'b0;
    logic       zero = 1'b0;
    logic       div_zero = 1'b0;
    logic       mult_done = 1'b0;
    logic       div_done = 1'b0;

    logic pc_write, mem_write, ir_write, reg_write, ab_write, mdr_write, alu_out_write;
    logic epc_write, mult_start, div_start, hilo_write;
    logic [1:0] iord, excp_control, alu_src_a, alu_src_b, ls_control;
    logic [2:0] alu_control, src_write, pc_source, shift_control;
    logic [3:0] src_data;
    ctrl_t dut_c;

    step_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc_in_instr = 0;
    string cur_name = "reset";

    control_unit #(.MemWait(MemWait)) dut (
        .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct),
        .overflow_i(overflow), .zero_i(zero), .div_zero_i(div_zero),
        .mult_done_i(mult_done), .div_done_i(div_done),
        .pc_write_o(pc_write), .mem_write_o(mem_write), .ir_write_o(ir_write),
        .reg_write_o(reg_write), .ab_write_o(ab_write), .mdr_write_o(mdr_write),
        .alu_out_write_o(alu_out_write), .epc_write_o(epc_write),
        .mult_start_o(mult_start), .div_start_o(div_start), .hilo_write_o(hilo_write),
        .iord_o(iord), .excp_control_o(excp_control), .alu_src_a_o(alu_src_a),
        .alu_src_b_o(alu_src_b), .alu_control_o(alu_control), .src_write_o(src_write),
        .src_data_o(src_data), .pc_source_o(pc_source), .ls_control_o(ls_control),
        .shift_control_o(shift_control)
    );

    always #5 clk = ~clk;

    always_comb begin
        dut_c               = '0;
        dut_c.pc_write      = pc_write;
        dut_c.mem_write     = mem_write;
        dut_c.ir_write      = ir_write;
        dut_c.reg_write     = reg_write;
        dut_c.ab_write      = ab_write;
        dut_c.mdr_write     = mdr_write;
        dut_c.alu_out_write = alu_out_write;
        dut_c.epc_write     = epc_write;
        dut_c.mult_start    = mult_start;
        dut_c.div_start     = div_start;
        dut_c.hilo_write    = hilo_write;
        dut_c.iord          = iord;
        dut_c.excp_control  = excp_control;
        dut_c.alu_src_a     = alu_src_a;
        dut_c.alu_src_b     = alu_src_b;
        dut_c.alu_control   = alu_control;
        dut_c.src_write     = src_write;
        dut_c.src_data      = src_data;
        dut_c.pc_source     = pc_source;
        dut_c.ls_control    = ls_control;
        dut_c.shift_control = shift_control;
    end

    task automatic check_word(string name, ctrl_t got, ctrl_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %h want %h", name, cyc_in_instr, got, want);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // ---- reference model: control words as micro-operations of each instruction ----
    function automatic ctrl_t alu_w(logic [1:0] a, logic [1:0] b, logic [2:0] op);
        ctrl_t c = '0;
        c.alu_src_a   = a;
        c.alu_src_b   = b;
        c.alu_control = op;
        return c;
    endfunction

    function automatic ctrl_t wr_w(logic [2:0] dst, logic [3:0] data);
        ctrl_t c = '0;
        c.reg_write = 1'b1;
        c.src_write = dst;
        c.src_data  = data;
        return c;
    endfunction

    function automatic ctrl_t pc_w(logic [2:0] src);
        ctrl_t c = '0;
        c.pc_write  = 1'b1;
        c.pc_source = src;
        return c;
    endfunction

    task automatic push(ctrl_t c, logic md = 1'b0, logic dd = 1'b0);
        step_t s;
        s.c  = c;
        s.md = md;
        s.dd = dd;
        exp_q.push_back(s);
    endtask

    task automatic push_exc(logic [1:0] code);
        ctrl_t c;
        c = alu_w(SrcAPc, SrcB4, AluSub);
        c.epc_write = 1'b1;
        c.excp_control = code;
        push(c);
        for (int i = 0; i < MemWait; i++) begin
            c = '0;
            c.iord = IordExcp;
            c.excp_control = code;
            push(c);
        end
        c = pc_w(PcLs);
        c.iord = IordExcp;
        c.excp_control = code;
        c.ls_control = LsByte;
        push(c);
    endtask

    task automatic plan(kind_e k, bit ovf, bit zr, bit dz, int wn);
        ctrl_t c;
        for (int i = 0; i <= MemWait; i++) begin
            c = alu_w(SrcAPc, SrcB4, AluAdd);
            if (i == MemWait) begin
                c.ir_write = 1'b1;
                c.pc_write = 1'b1;
            end
            push(c);
        end
        c = alu_w(SrcAPc, SrcBImmSh, AluAdd);
        c.ab_write = 1'b1;
        c.alu_out_write = 1'b1;
        push(c);
        case (k)
            KAdd, KSub, KAnd, KAddi: begin
                c = alu_w(SrcAA, (k == KAddi) ? SrcBImm : SrcBB,
                          (k == KSub) ? AluSub : (k == KAnd) ? AluAnd : AluAdd);
                c.alu_out_write = 1'b1;
                push(c);
                if (ovf && k != KAnd) push_exc(ExcpOvf);
                else push(wr_w((k == KAddi) ? WrRt : WrRd, DataAluOut));
            end
            KLui: push(wr_w(WrRt, DataLui));
            KLw, KSw: begin
                c = alu_w(SrcAA, SrcBImm, AluAdd);
                c.alu_out_write = 1'b1;
                push(c);
                c = '0;
                c.iord = IordAluOut;
                if (k == KSw) begin
                    c.mem_write = 1'b1;
                    push(c);
                end else begin
                    for (int i = 0; i < MemWait; i++) push(c);
                    c.mdr_write = 1'b1;
                    push(c);
                    push(wr_w(WrRt, DataLs));
                end
            end
            KBeq, KBne: begin
                push(alu_w(SrcAA, SrcBB, AluCmp));
                if ((k == KBeq) == zr) push(pc_w(PcAluOut));
            end
            KJ: push(pc_w(PcJump));
            KJal: begin
                c = pc_w(PcJump);
                c.reg_write = 1'b1;
                c.src_write = WrRa;
                c.src_data = DataPc;
                push(c);
            end
            KJr: begin
                c = alu_w(SrcAA, SrcBB, AluPassA);
                c.pc_write = 1'b1;
                push(c);
            end
            KSll, KSrl: begin
                c = '0;
                c.shift_control = ShLoad;
                push(c);
                c.shift_control = (k == KSll) ? ShSll : ShSrl;
                push(c);
                push(wr_w(WrRd, DataShift));
            end
            KMfhi: push(wr_w(WrRd, DataHi));
            KMflo: push(wr_w(WrRd, DataLo));
            KRte: push(pc_w(PcEpc));
            KBreak: begin
                c = alu_w(SrcAPc, SrcB4, AluSub);
                c.pc_write = 1'b1;
                push(c);
            end
            KMult, KDiv: begin
                c = '0;
                if (k == KMult) c.mult_start = 1'b1;
                else c.div_start = 1'b1;
                push(c);
                if (k == KDiv && dz) begin
                    push_exc(ExcpDiv0);
                end else begin
                    for (int i = 1; i <= wn; i++)
                        push('0, (k == KMult) && (i == wn), (k == KDiv) && (i == wn));
                    c = '0;
                    c.hilo_write = 1'b1;
                    push(c);
                end
            end
            default: push_exc(ExcpOp);
        endcase
    endtask

    task automatic encode(kind_e k, output logic [5:0] op, output logic [5:0] fn);
        logic [5:0] rnd;
        rnd = 6'($urandom);
        op = OpR;
        fn = rnd;
        case (k)
            KAdd:   fn = FnAdd;
            KSub:   fn = FnSub;
            KAnd:   fn = FnAnd;
            KSll:   fn = FnSll;
            KSrl:   fn = FnSrl;
            KJr:    fn = FnJr;
            KMfhi:  fn = FnMfhi;
            KMflo:  fn = FnMflo;
            KRte:   fn = FnRte;
            KBreak: fn = FnBreak;
            KMult:  fn = FnMult;
            KDiv:   fn = FnDiv;
            KBadFn: fn = 6'h3F;
            KAddi:  op = OpAddi;
            KLui:   op = OpLui;
            KLw:    op = OpLw;
            KSw:    op = OpSw;
            KBeq:   op = OpBeq;
            KBne:   op = OpBne;
            KJ:     op = OpJ;
            KJal:   op = OpJal;
            default: op = 6'h3F;
        endcase
    endtask

    // Compare process: one expected word per cycle; also plays the mult/div done pulses.
    always @(negedge clk) begin
        step_t s;
        if (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            check_word(cur_name, dut_c, s.c);
            cyc_in_instr++;
            mult_done = s.md;
            div_done = s.dd;
        end else begin
            mult_done = 1'b0;
            div_done = 1'b0;
        end
    end

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            guard++;
            if (guard > 400) begin
                checks++;
                errors++;
                $display("FAIL drain_timeout %s got %0d want 0 pending", cur_name, exp_q.size());
                exp_q.delete();
            end
        end
        #1;
    endtask

    task automatic start(kind_e k, bit ovf, bit zr, bit dz, int wn);
        logic [5:0] op, fn;
        encode(k, op, fn);
        opcode = op;
        funct = fn;
        overflow = ovf;
        zero = zr;
        div_zero = dz;
        cur_name = k.name();
        cyc_in_instr = 0;
        plan(k, ovf, zr, dz, wn);
    endtask

    task automatic run(kind_e k, bit ovf, bit zr, bit dz, int wn, int pin_len = -1);
        start(k, ovf, zr, dz, wn);
        if (pin_len >= 0) check_int({"len_", k.name()}, exp_q.size(), pin_len);
        drain();
    endtask

    task automatic release_reset();
        ctrl_t lit;
        lit = '0;
        lit.reg_write = 1'b1;
        lit.src_write = 3'd2;
        lit.src_data = 4'd8;
        rst = 1'b0;
        #1;
        check_word("reset_sp_init", dut_c, lit);
        cur_name = "reset_state";
        push(wr_w(WrSp, DataSpInit));
        drain();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_word("reset_hold", dut_c, '0);
        release_reset();

        // Directed cases with hand-derived cycle counts (MemWait = 2).
        run(KAdd, 1'b0, 1'b0, 1'b0, 1, 6);
        run(KAdd, 1'b1, 1'b0, 1'b0, 1, 9);
        run(KBeq, 1'b0, 1'b1, 1'b0, 1, 6);
        run(KBne, 1'b0, 1'b1, 1'b0, 1, 5);
        run(KDiv, 1'b0, 1'b0, 1'b1, 1, 9);
        run(KDiv, 1'b0, 1'b0, 1'b0, 32, 38);
        run(KBadOp, 1'b0, 1'b0, 1'b0, 1, 8);
        run(KRte, 1'b0, 1'b0, 1'b0, 1, 5);
        run(KLw, 1'b0, 1'b0, 1'b0, 1, 9);

        // Asynchronous reset in the middle of DIV_WAIT.
        start(KDiv, 1'b0, 1'b0, 1'b0, 60);
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_word("reset_async", dut_c, '0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_word("reset_mid_div", dut_c, '0);
        end
        release_reset();
        run(KAdd, 1'b0, 1'b0, 1'b0, 1, 6);

        for (int n = 0; n < 250; n++) begin
            run(kind_e'($urandom_range(0, 21)), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0), int'($urandom_range(1, 40)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
